// File: rtl/synth_pkg.sv
// synth_pkg: shared types and defaults for the synth voice path and its MIDI front end.
package synth_pkg;
    localparam int NOTE_W_DEFAULT = 7;
    typedef enum logic [1:0] {IDLE, DECIDE, DROP} state_t;
    typedef struct packed {
        logic                      on;
        logic [NOTE_W_DEFAULT-1:0] num;
    } note_event_t;
endpackage

// File: rtl/voice_pick.sv
// voice_pick: lowest-index-set priority encoder over a voice mask.
module voice_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         found
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (mask[i]) idx = W'(i);
    end
    assign found = |mask;
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note events to ADSR voices, preferring retrigger, idle, releasing, then round-robin steal.
module voice_allocator import synth_pkg::*; #(
    parameter  int NUM_VOICES = 4,
    parameter  int NOTE_W     = NOTE_W_DEFAULT,
    localparam int VW         = $clog2(NUM_VOICES)
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         NoteValid,
    output logic                         NoteReady,
    input  logic                         NoteOn,
    input  logic [NOTE_W-1:0]            NoteNum,
    input  logic [NUM_VOICES-1:0]        VoiceRunning,
    output logic [NUM_VOICES-1:0]        VoiceGate,
    output logic [NUM_VOICES*NOTE_W-1:0] VoiceNote,
    output logic                         AllocValid,
    output logic [VW-1:0]                AllocVoice,
    output logic                         Stolen
);
    state_t                       state_q, state_d;
    logic                         ready_q, ready_d;
    logic                         ev_on_q, ev_on_d;
    logic [NOTE_W-1:0]            ev_num_q, ev_num_d;
    logic [NUM_VOICES-1:0]        gate_q, gate_d;
    logic [NUM_VOICES*NOTE_W-1:0] note_q, note_d;
    logic [VW-1:0]                steal_ptr_q, steal_ptr_d;
    logic [VW-1:0]                target_q, target_d;
    logic                         steal_q, steal_d;
    logic                         alloc_valid_q, alloc_valid_d;
    logic [VW-1:0]                alloc_voice_q, alloc_voice_d;
    logic                         stolen_q, stolen_d;
    logic [NUM_VOICES-1:0]        match_mask, idle_mask, rel_mask;
    logic [VW-1:0]                match_idx, idle_idx, rel_idx, pick;
    logic                         match_found, idle_found, rel_found;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_match
        assign match_mask[i] = gate_q[i] && (note_q[i*NOTE_W +: NOTE_W] == ev_num_q);
    end
    assign idle_mask = ~gate_q & ~VoiceRunning;
    assign rel_mask  = ~gate_q & VoiceRunning;

    voice_pick #(.N(NUM_VOICES)) u_match (.mask(match_mask), .idx(match_idx), .found(match_found));
    voice_pick #(.N(NUM_VOICES)) u_idle  (.mask(idle_mask),  .idx(idle_idx),  .found(idle_found));
    voice_pick #(.N(NUM_VOICES)) u_rel   (.mask(rel_mask),   .idx(rel_idx),   .found(rel_found));

    always_comb begin
        state_d       = state_q;
        ev_on_d       = ev_on_q;
        ev_num_d      = ev_num_q;
        gate_d        = gate_q;
        note_d        = note_q;
        steal_ptr_d   = steal_ptr_q;
        target_d      = target_q;
        steal_d       = steal_q;
        alloc_valid_d = 1'b0;
        alloc_voice_d = alloc_voice_q;
        stolen_d      = 1'b0;
        pick          = match_found ? match_idx : idle_found ? idle_idx : rel_found ? rel_idx : steal_ptr_q;
        case (state_q)
            IDLE: begin
                if (NoteValid && ready_q) begin
                    ev_on_d  = NoteOn;
                    ev_num_d = NoteNum;
                    state_d  = DECIDE;
                end
            end
            DECIDE: begin
                state_d = IDLE;
                if (ev_on_q) begin
                    steal_d  = !(match_found || idle_found || rel_found);
                    target_d = pick;
                    note_d[int'(pick)*NOTE_W +: NOTE_W] = ev_num_q;
                    if (steal_d)
                        steal_ptr_d = (steal_ptr_q == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
                    // A gated target gets one low cycle so its ADSR restarts the attack.
                    if (gate_q[pick]) begin
                        gate_d[pick] = 1'b0;
                        state_d      = DROP;
                    end else begin
                        gate_d[pick]  = 1'b1;
                        alloc_valid_d = 1'b1;
                        alloc_voice_d = pick;
                    end
                end else if (match_found) begin
                    gate_d[match_idx] = 1'b0;
                end
            end
            DROP: begin
                gate_d[target_q] = 1'b1;
                alloc_valid_d    = 1'b1;
                alloc_voice_d    = target_q;
                stolen_d         = steal_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            ev_on_q       <= 1'b0;
            ev_num_q      <= '0;
            gate_q        <= '0;
            note_q        <= '0;
            steal_ptr_q   <= '0;
            target_q      <= '0;
            steal_q       <= 1'b0;
            alloc_valid_q <= 1'b0;
            alloc_voice_q <= '0;
            stolen_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            ev_on_q       <= ev_on_d;
            ev_num_q      <= ev_num_d;
            gate_q        <= gate_d;
            note_q        <= note_d;
            steal_ptr_q   <= steal_ptr_d;
            target_q      <= target_d;
            steal_q       <= steal_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_voice_q <= alloc_voice_d;
            stolen_q      <= stolen_d;
        end
    end

    assign NoteReady  = ready_q;
    assign VoiceGate  = gate_q;
    assign VoiceNote  = note_q;
    assign AllocValid = alloc_valid_q;
    assign AllocVoice = alloc_voice_q;
    assign Stolen     = stolen_q;
endmodule
